// File: rtl/uart_fifo_core.sv
// UART core: 16x baud generator, TX/RX engines, FIFOs each way, sticky line errors.
// Ports: i_clk/i_rst, i_rx/o_tx pins, TX FIFO write side, RX FIFO FWFT read side, error flags/clear.
module uart_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int D = 2**AW;
  localparam logic [AW:0] FULLV = (AW+1)'(D);

  logic [W-1:0]  mem_q [D];
  logic [W-1:0]  mem_d [D];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    o_full  = (cnt_q == FULLV);
    o_empty = (cnt_q == '0);
    o_dout  = mem_q[rp_q];
    do_push = i_push && !o_full;
    do_pop  = i_pop && !o_empty;
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wp_q] = i_din;
      wp_d        = wp_q + 1'b1;
    end
    if (do_pop) rp_d = rp_q + 1'b1;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < D; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module uart_fifo_core #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 19200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic                 o_tx,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_wr,
  output logic                 o_tx_full,
  output logic                 o_tx_empty,
  output logic                 o_tx_busy,
  output logic [DATA_BITS-1:0] o_rx_data,
  input  logic                 i_rx_rd,
  output logic                 o_rx_empty,
  output logic                 o_rx_full,
  output logic                 o_err_parity,
  output logic                 o_err_frame,
  output logic                 o_err_overrun,
  input  logic                 i_err_clr
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BMAX = CW'(DIV - 1);
  localparam logic [3:0] LAST = 4'(DATA_BITS - 1);
  localparam logic [4:0] STOP_END = 5'(16 * STOP_BITS - 1);

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_st_e;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BRK} rx_st_e;

  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  logic [CW-1:0] bcnt_q, bcnt_d;
  logic          tick;

  always_comb begin
    tick   = (bcnt_q == BMAX);
    bcnt_d = tick ? '0 : bcnt_q + 1'b1;
  end

  logic                 txf_pop, txf_empty;
  logic [DATA_BITS-1:0] txf_dout;
  logic                 rxf_push, rxf_full;
  logic [DATA_BITS-1:0] rsh_q, rsh_d;

  uart_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_txf (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_push(i_tx_wr), .i_din(i_tx_data),
    .i_pop(txf_pop), .o_dout(txf_dout),
    .o_full(o_tx_full), .o_empty(txf_empty)
  );

  uart_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_rxf (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_push(rxf_push), .i_din(rsh_q),
    .i_pop(i_rx_rd), .o_dout(o_rx_data),
    .o_full(rxf_full), .o_empty(o_rx_empty)
  );

  assign o_tx_empty = txf_empty;
  assign o_rx_full  = rxf_full;

  tx_st_e               txs_q, txs_d;
  logic [4:0]           ttc_q, ttc_d;
  logic [3:0]           tbit_q, tbit_d;
  logic [DATA_BITS-1:0] tsh_q, tsh_d;
  logic                 tpar_q, tpar_d, tx_q, tx_d;

  always_comb begin
    txs_d   = txs_q;
    ttc_d   = ttc_q;
    tbit_d  = tbit_q;
    tsh_d   = tsh_q;
    tpar_d  = tpar_q;
    txf_pop = 1'b0;
    if (tick) begin
      ttc_d = ttc_q + 1'b1;
      unique case (txs_q)
        T_IDLE: begin
          ttc_d = '0;
          if (!txf_empty) begin
            txf_pop = 1'b1;
            tsh_d   = txf_dout;
            tpar_d  = par_of(txf_dout);
            txs_d   = T_START;
          end
        end
        T_START: if (ttc_q == 5'd15) begin
          ttc_d  = '0;
          tbit_d = '0;
          txs_d  = T_DATA;
        end
        T_DATA: if (ttc_q == 5'd15) begin
          ttc_d = '0;
          if (tbit_q == LAST) begin
            if (PARITY != 0) txs_d = T_PAR;
            else txs_d = T_STOP;
          end else begin
            tbit_d = tbit_q + 1'b1;
            tsh_d  = tsh_q >> 1;
          end
        end
        T_PAR: if (ttc_q == 5'd15) begin
          ttc_d = '0;
          txs_d = T_STOP;
        end
        default: if (ttc_q == STOP_END) begin
          ttc_d = '0;
          // Chain straight into the next start bit when more data waits.
          if (!txf_empty) begin
            txf_pop = 1'b1;
            tsh_d   = txf_dout;
            tpar_d  = par_of(txf_dout);
            txs_d   = T_START;
          end else begin
            txs_d = T_IDLE;
          end
        end
      endcase
    end
    unique case (txs_d)
      T_IDLE:  tx_d = 1'b1;
      T_START: tx_d = 1'b0;
      T_DATA:  tx_d = tsh_d[0];
      T_PAR:   tx_d = tpar_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign o_tx      = tx_q;
  assign o_tx_busy = (txs_q != T_IDLE);

  logic [1:0] sync_q, sync_d;
  logic       rxs;
  rx_st_e     rxs_q, rxs_d;
  logic [3:0] rtc_q, rtc_d, rbit_q, rbit_d;
  logic       rbad_q, rbad_d;
  logic       set_par, set_frm, set_ovr;
  logic       pe_q, pe_d, fe_q, fe_d, oe_q, oe_d;

  always_comb begin
    sync_d   = {sync_q[0], i_rx};
    rxs      = sync_q[1];
    rxs_d    = rxs_q;
    rtc_d    = rtc_q;
    rbit_d   = rbit_q;
    rsh_d    = rsh_q;
    rbad_d   = rbad_q;
    rxf_push = 1'b0;
    set_par  = 1'b0;
    set_frm  = 1'b0;
    if (tick) rtc_d = rtc_q + 1'b1;
    unique case (rxs_q)
      R_IDLE: begin
        rtc_d = '0;
        if (!rxs) rxs_d = R_START;
      end
      R_START: if (tick && rtc_q == 4'd7) begin
        rtc_d = '0;
        if (!rxs) begin
          rxs_d  = R_DATA;
          rbit_d = '0;
          rbad_d = 1'b0;
        end else begin
          rxs_d = R_IDLE;
        end
      end
      R_DATA: if (tick && rtc_q == 4'd15) begin
        rsh_d  = {rxs, rsh_q[DATA_BITS-1:1]};
        rbit_d = rbit_q + 1'b1;
        if (rbit_q == LAST) begin
          if (PARITY != 0) rxs_d = R_PAR;
          else rxs_d = R_STOP;
        end
      end
      R_PAR: if (tick && rtc_q == 4'd15) begin
        if (rxs != par_of(rsh_q)) begin
          set_par = 1'b1;
          rbad_d  = 1'b1;
        end
        rxs_d = R_STOP;
      end
      R_STOP: if (tick && rtc_q == 4'd15) begin
        if (!rxs) begin
          set_frm = 1'b1;
          rxs_d   = R_BRK;
        end else begin
          rxf_push = !rbad_q;
          rxs_d    = R_IDLE;
        end
      end
      default: if (rxs) rxs_d = R_IDLE;
    endcase
    set_ovr = rxf_push && rxf_full;
    // A set in the same cycle as a clear keeps the flag raised.
    pe_d = (pe_q & ~i_err_clr) | set_par;
    fe_d = (fe_q & ~i_err_clr) | set_frm;
    oe_d = (oe_q & ~i_err_clr) | set_ovr;
  end

  assign o_err_parity  = pe_q;
  assign o_err_frame   = fe_q;
  assign o_err_overrun = oe_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bcnt_q <= '0;
      txs_q  <= T_IDLE;
      ttc_q  <= '0;
      tbit_q <= '0;
      tsh_q  <= '0;
      tpar_q <= 1'b0;
      tx_q   <= 1'b1;
      sync_q <= 2'b11;
      rxs_q  <= R_IDLE;
      rtc_q  <= '0;
      rbit_q <= '0;
      rsh_q  <= '0;
      rbad_q <= 1'b0;
      pe_q   <= 1'b0;
      fe_q   <= 1'b0;
      oe_q   <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      txs_q  <= txs_d;
      ttc_q  <= ttc_d;
      tbit_q <= tbit_d;
      tsh_q  <= tsh_d;
      tpar_q <= tpar_d;
      tx_q   <= tx_d;
      sync_q <= sync_d;
      rxs_q  <= rxs_d;
      rtc_q  <= rtc_d;
      rbit_q <= rbit_d;
      rsh_q  <= rsh_d;
      rbad_q <= rbad_d;
      pe_q   <= pe_d;
      fe_q   <= fe_d;
      oe_q   <= oe_d;
    end
  end
endmodule
